// File: rtl/trade_engine_arbiter_if.sv
// Bundle of requester, engine and response handshakes around the shared trade_decision engine.
// The slave modport is the arbiter's view; master is the surrounding client logic.
interface trade_engine_arbiter_if #(
  parameter int num_req_p     = 2,
  parameter int msg_width_p   = 178,
  parameter int trade_width_p = 178,
  parameter int max_out_p     = 4
);
  localparam int cnt_width_lp = $clog2(max_out_p) + 1;

  logic                             en_i;
  logic [num_req_p-1:0]             req_v_i;
  logic [num_req_p*msg_width_p-1:0] req_data_i;
  logic [num_req_p-1:0]             req_ready_o;
  logic                             eng_v_o;
  logic [msg_width_p-1:0]           eng_data_o;
  logic                             eng_ready_i;
  logic                             eng_v_i;
  logic [trade_width_p-1:0]         eng_data_i;
  logic                             eng_yumi_o;
  logic [num_req_p-1:0]             resp_v_o;
  logic [trade_width_p-1:0]         resp_data_o;
  logic [num_req_p-1:0]             resp_yumi_i;
  logic [cnt_width_lp-1:0]          out_cnt_o;
  logic                             err_o;

  modport slave (
    input  en_i, req_v_i, req_data_i, eng_ready_i, eng_v_i, eng_data_i, resp_yumi_i,
    output req_ready_o, eng_v_o, eng_data_o, eng_yumi_o, resp_v_o, resp_data_o, out_cnt_o, err_o
  );

  modport master (
    output en_i, req_v_i, req_data_i, eng_ready_i, eng_v_i, eng_data_i, resp_yumi_i,
    input  req_ready_o, eng_v_o, eng_data_o, eng_yumi_o, resp_v_o, resp_data_o, out_cnt_o, err_o
  );
endinterface

// File: rtl/trade_engine_arbiter.sv
// Round-robin issue of requester messages into one shared engine, with an in-order tag FIFO
// that steers each engine result back to the requester that issued it.
module trade_engine_arbiter #(
  parameter int num_req_p     = 2,
  parameter int msg_width_p   = 178,
  parameter int trade_width_p = 178,
  parameter int max_out_p     = 4
) (
  input logic                  clk_i,
  input logic                  reset_i,
  trade_engine_arbiter_if.slave bus
);
  localparam int ptr_width_lp = $clog2(max_out_p);
  localparam int cnt_width_lp = $clog2(max_out_p) + 1;
  localparam int id_width_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  localparam logic [cnt_width_lp-1:0] max_cnt_lp  = cnt_width_lp'(max_out_p);
  localparam logic [id_width_lp-1:0]  last_id_lp  = id_width_lp'(num_req_p - 1);
  localparam logic [id_width_lp:0]    num_req_lp  = (id_width_lp + 1)'(num_req_p);

  logic [id_width_lp-1:0]  tag_mem [max_out_p];
  logic [ptr_width_lp-1:0] rd_ptr;
  logic [ptr_width_lp-1:0] wr_ptr;
  logic [cnt_width_lp-1:0] out_cnt;
  logic [id_width_lp-1:0]  rr_ptr;
  logic                    err_r;

  logic [id_width_lp:0]    scan_sum;
  logic [id_width_lp-1:0]  scan_idx;
  logic [id_width_lp-1:0]  grant_idx;
  logic [id_width_lp-1:0]  head_idx;
  logic [id_width_lp-1:0]  rr_next;
  logic [num_req_p-1:0]    grant_oh;
  logic [num_req_p-1:0]    resp_v;
  logic                    grant_found;
  logic                    can_issue;
  logic                    empty;
  logic                    issue_v;
  logic                    issue;
  logic                    resp_any;
  logic                    pop;
  logic                    err_set;

  // First valid requester at or after rr_ptr, wrapping modulo num_req_p
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < num_req_p; k++) begin
      scan_sum = {1'b0, rr_ptr} + (id_width_lp + 1)'(k);
      if (scan_sum >= num_req_lp) scan_sum = scan_sum - num_req_lp;
      scan_idx = scan_sum[id_width_lp-1:0];
      if (!grant_found && bus.req_v_i[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Reset gates every combinational output so nothing leaks while the engine is also held
  always_comb begin
    can_issue = bus.en_i && (out_cnt < max_cnt_lp);
    empty     = (out_cnt == '0);
    head_idx  = tag_mem[rd_ptr];

    grant_oh = '0;
    if (grant_found) grant_oh[grant_idx] = 1'b1;

    issue_v = !reset_i && can_issue && grant_found;
    issue   = issue_v && bus.eng_ready_i;

    resp_any = !reset_i && bus.eng_v_i && !empty;
    resp_v   = '0;
    if (resp_any) resp_v[head_idx] = 1'b1;
    pop = resp_any && bus.resp_yumi_i[head_idx];

    err_set = (bus.eng_v_i && empty) || (|(bus.resp_yumi_i & ~resp_v));
    rr_next = (grant_idx == last_id_lp) ? '0 : grant_idx + 1'b1;

    bus.eng_v_o     = issue_v;
    bus.eng_data_o  = (!reset_i && grant_found) ? bus.req_data_i[grant_idx*msg_width_p +: msg_width_p] : '0;
    bus.req_ready_o = (!reset_i && can_issue && bus.eng_ready_i) ? grant_oh : '0;
    bus.resp_v_o    = resp_v;
    bus.eng_yumi_o  = pop;
  end

  assign bus.resp_data_o = bus.eng_data_i;
  assign bus.out_cnt_o   = out_cnt;
  assign bus.err_o       = err_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      out_cnt <= '0;
      rr_ptr  <= '0;
      err_r   <= 1'b0;
    end else begin
      if (issue) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= rr_next;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({issue, pop})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
      if (err_set) err_r <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read while out_cnt marks them live
  always_ff @(posedge clk_i) begin
    if (issue) tag_mem[wr_ptr] <= grant_idx;
  end
endmodule

// File: tb/tb_trade_engine_arbiter.sv
// Randomized and directed bench for trade_engine_arbiter against a queue-based reference model.
module tb_trade_engine_arbiter;
  localparam int N    = 2;
  localparam int MW   = 178;
  localparam int TW   = 178;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared   = 0;
  int mismatched = 0;

  trade_engine_arbiter_if #(.num_req_p(N), .msg_width_p(MW), .trade_width_p(TW), .max_out_p(MAXO)) bus();

  trade_engine_arbiter #(.num_req_p(N), .msg_width_p(MW), .trade_width_p(TW), .max_out_p(MAXO)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct { int tag; logic [MW-1:0] msg; } tag_t;
  typedef struct { logic [MW-1:0] msg; int due; } eng_t;

  tag_t mq[$];
  int   m_rr  = 0;
  bit   m_err = 1'b0;

  logic [N-1:0]  e_ready, e_resp;
  logic          e_ev, e_yumi, e_err;
  logic [MW-1:0] e_data;
  int            e_cnt, e_gidx;
  bit            e_push, e_pop, e_errnext;

  eng_t epipe[$];
  int   lat = 1, present_pct = 100, yumi_pct = 100, cyc = 0;
  bit   eng_hold = 1'b0, eng_force = 1'b0, auto_yumi = 1'b1;

  function automatic logic [MW-1:0] randMsg();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[MW-1:0];
  endfunction

  function automatic logic [MW-1:0] mkMsg(input int n);
    logic [MW-1:0] m;
    m = '0;
    m[31:0] = n;
    m[MW-1 -: 8] = 8'hA5;
    return m;
  endfunction

  function automatic logic [TW-1:0] xform(input logic [MW-1:0] m);
    return ~m;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs derived from the rules: rotating search from the pointer, queue head owns the result
  task automatic computeExpected();
    e_ready = '0; e_resp = '0; e_ev = 1'b0; e_yumi = 1'b0; e_data = '0;
    e_gidx = -1; e_push = 1'b0; e_pop = 1'b0; e_errnext = m_err;
    e_cnt = rst ? 0 : mq.size();
    e_err = rst ? 1'b0 : m_err;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (e_gidx < 0 && bus.req_v_i[idx]) e_gidx = idx;
      end
      if (e_gidx >= 0) begin
        e_data = bus.req_data_i[e_gidx*MW +: MW];
        e_ev = bus.en_i && (mq.size() < MAXO);
        if (e_ev && bus.eng_ready_i) e_ready[e_gidx] = 1'b1;
      end
      e_push = e_ev && bus.eng_ready_i;
      if (mq.size() > 0 && bus.eng_v_i) begin
        e_resp[mq[0].tag] = 1'b1;
        if (bus.resp_yumi_i[mq[0].tag]) begin
          e_yumi = 1'b1;
          e_pop  = 1'b1;
        end
      end
      if (bus.eng_v_i && mq.size() == 0) e_errnext = 1'b1;
      for (int j = 0; j < N; j++)
        if (bus.resp_yumi_i[j] && !e_resp[j]) e_errnext = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_rr  = 0;
      m_err = 1'b0;
    end else begin
      computeExpected();
      if (e_pop) void'(mq.pop_front());
      if (e_push) begin
        mq.push_back('{e_gidx, e_data});
        m_rr = (e_gidx + 1) % N;
      end
      m_err = e_errnext;
    end
  end

  always @(negedge clk) begin
    computeExpected();
    checkOutput("req_ready", bus.req_ready_o, e_ready);
    checkOutput("eng_v", bus.eng_v_o, e_ev);
    checkOutput("eng_data", bus.eng_data_o, e_data);
    checkOutput("eng_yumi", bus.eng_yumi_o, e_yumi);
    checkOutput("resp_v", bus.resp_v_o, e_resp);
    checkOutput("resp_data", bus.resp_data_o, bus.eng_data_i);
    checkOutput("out_cnt", bus.out_cnt_o, e_cnt);
    checkOutput("err", bus.err_o, e_err);
  end

  // Engine and auto-consume behaviour for the cycle, then settle to posedge+3
  task automatic applyStimulus();
    if (eng_force) begin
      bus.eng_v_i = 1'b1;
      bus.eng_data_i = randMsg();
    end else if (!eng_hold && epipe.size() > 0 && epipe[0].due <= cyc &&
                 $urandom_range(99) < present_pct) begin
      bus.eng_v_i = 1'b1;
      bus.eng_data_i = xform(epipe[0].msg);
    end else begin
      bus.eng_v_i = 1'b0;
      bus.eng_data_i = randMsg();
    end
    #1;
    if (auto_yumi) bus.resp_yumi_i = ($urandom_range(99) < yumi_pct) ? bus.resp_v_o : '0;
    #1;
  endtask

  task automatic endCycle();
    if (bus.eng_yumi_o && epipe.size() > 0) void'(epipe.pop_front());
    if (bus.eng_v_o && bus.eng_ready_i) epipe.push_back('{bus.eng_data_o, cyc + lat});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.en_i = 1'b1; bus.req_v_i = '0; bus.eng_ready_i = 1'b1; bus.eng_v_i = 1'b0;
    bus.resp_yumi_i = '0; bus.eng_data_i = randMsg();
    for (int i = 0; i < N; i++) bus.req_data_i[i*MW +: MW] = randMsg();
    epipe.delete();
    eng_hold = 1'b0; eng_force = 1'b0; auto_yumi = 1'b1;
    yumi_pct = 100; present_pct = 100; lat = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    int pulses, peak, issues, ret;
    doReset();

    // Single requester, 2-cycle engine latency
    lat = 2; pulses = 0; peak = 0;
    for (int n = 0; n < 9; n++) begin
      bus.req_v_i = (n < 3) ? 2'b01 : 2'b00;
      bus.req_data_i[0 +: MW] = mkMsg(n + 1);
      applyStimulus();
      if (int'(bus.out_cnt_o) > peak) peak = int'(bus.out_cnt_o);
      if (bus.resp_v_o[0] && bus.eng_yumi_o) begin
        if (pulses < 3) checkOutput($sformatf("t1_data%0d", pulses), bus.resp_data_o, xform(mkMsg(pulses + 1)));
        pulses++;
      end
      endCycle();
    end
    checkOutput("t1_pulses", pulses, 3);
    checkOutput("t1_peak", peak, 2);
    checkOutput("t1_cnt_end", bus.out_cnt_o, 0);
    checkOutput("t1_err", bus.err_o, 0);

    // Fairness between two always-valid requesters
    doReset();
    bus.req_v_i = 2'b11;
    bus.req_data_i[0 +: MW] = mkMsg(100);
    bus.req_data_i[MW +: MW] = mkMsg(200);
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      checkOutput($sformatf("t2_grant%0d", i), bus.req_ready_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      endCycle();
    end
    bus.req_v_i = '0;
    repeat (4) begin applyStimulus(); endCycle(); end
    checkOutput("t2_cnt_end", bus.out_cnt_o, 0);

    // Full: engine holds results while five issues are attempted
    doReset();
    eng_hold = 1'b1; issues = 0;
    bus.req_v_i = 2'b01;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      if (bus.eng_v_o && bus.eng_ready_i) issues++;
      endCycle();
    end
    checkOutput("t3_issues", issues, 4);
    eng_hold = 1'b0;
    applyStimulus();
    checkOutput("t3_ready_full", bus.req_ready_o, 2'b00);
    checkOutput("t3_cnt_full", bus.out_cnt_o, 4);
    checkOutput("t3_no_bypass", bus.eng_v_o, 0);
    checkOutput("t3_yumi", bus.eng_yumi_o, 1);
    endCycle();
    eng_hold = 1'b1;
    applyStimulus();
    checkOutput("t3_resume", bus.eng_v_o, 1);
    checkOutput("t3_cnt_after", bus.out_cnt_o, 3);
    endCycle();
    bus.req_v_i = '0; eng_hold = 1'b0;
    repeat (8) begin applyStimulus(); endCycle(); end
    checkOutput("t3_cnt_end", bus.out_cnt_o, 0);

    // Response back-pressure with a non-owner yumi
    doReset();
    auto_yumi = 1'b0;
    bus.req_v_i = 2'b10;
    bus.req_data_i[MW +: MW] = mkMsg(40);
    applyStimulus(); endCycle();
    bus.req_v_i = '0;
    for (int i = 0; i < 3; i++) begin
      bus.resp_yumi_i = (i == 0) ? 2'b00 : 2'b01;
      applyStimulus();
      checkOutput($sformatf("t4_resp_held%0d", i), bus.resp_v_o, 2'b10);
      checkOutput($sformatf("t4_no_yumi%0d", i), bus.eng_yumi_o, 0);
      endCycle();
    end
    bus.resp_yumi_i = 2'b10;
    applyStimulus();
    checkOutput("t4_err", bus.err_o, 1);
    checkOutput("t4_cnt_held", bus.out_cnt_o, 1);
    checkOutput("t4_yumi", bus.eng_yumi_o, 1);
    checkOutput("t4_data", bus.resp_data_o, xform(mkMsg(40)));
    endCycle();
    bus.resp_yumi_i = '0;
    applyStimulus();
    checkOutput("t4_cnt_end", bus.out_cnt_o, 0);
    endCycle();

    // Result with nothing in flight
    doReset();
    eng_force = 1'b1;
    applyStimulus();
    checkOutput("t5_no_resp", bus.resp_v_o, 2'b00);
    checkOutput("t5_no_yumi", bus.eng_yumi_o, 0);
    checkOutput("t5_err_before", bus.err_o, 0);
    endCycle();
    eng_force = 1'b0;
    applyStimulus();
    checkOutput("t5_err_after", bus.err_o, 1);
    endCycle();

    // Enable low blocks issue while an in-flight result drains
    doReset();
    lat = 2; ret = 0;
    bus.req_v_i = 2'b01;
    bus.req_data_i[0 +: MW] = mkMsg(7);
    applyStimulus(); endCycle();
    bus.en_i = 1'b0; bus.req_v_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput($sformatf("t5_en_block%0d", i), bus.eng_v_o, 0);
      if (bus.eng_yumi_o) ret++;
      endCycle();
    end
    checkOutput("t5_returns", ret, 1);
    checkOutput("t5_cnt_end", bus.out_cnt_o, 0);

    // Asynchronous reset with three in flight and a sticky error
    doReset();
    eng_hold = 1'b1; auto_yumi = 1'b0;
    bus.req_v_i = 2'b11;
    repeat (3) begin applyStimulus(); endCycle(); end
    bus.req_v_i = '0; eng_hold = 1'b0;
    bus.resp_yumi_i = 2'b10;
    applyStimulus(); endCycle();
    bus.resp_yumi_i = '0;
    applyStimulus();
    checkOutput("t6_cnt_pre", bus.out_cnt_o, 3);
    checkOutput("t6_err_pre", bus.err_o, 1);
    rst = 1'b1;
    #1;
    checkOutput("t6_cnt_rst", bus.out_cnt_o, 0);
    checkOutput("t6_resp_rst", bus.resp_v_o, 2'b00);
    checkOutput("t6_err_rst", bus.err_o, 0);
    checkOutput("t6_ev_rst", bus.eng_v_o, 0);
    epipe.delete();
    @(posedge clk);
    #1;
    rst = 1'b0; cyc = 0; eng_hold = 1'b1;
    bus.req_v_i = 2'b11;
    applyStimulus();
    checkOutput("t6_first_grant", bus.req_ready_o, 2'b01);
    endCycle();

    // Randomized traffic, protocol-legal on the requester side
    doReset();
    present_pct = 60; yumi_pct = 70;
    for (int c = 0; c < 800; c++) begin
      bus.en_i = ($urandom_range(9) != 0);
      bus.req_v_i = N'($urandom());
      for (int i = 0; i < N; i++) bus.req_data_i[i*MW +: MW] = randMsg();
      bus.eng_ready_i = ($urandom_range(3) != 0);
      lat = 1 + $urandom_range(2);
      applyStimulus();
      endCycle();
    end
    bus.req_v_i = '0; present_pct = 100; yumi_pct = 100;
    repeat (12) begin applyStimulus(); endCycle(); end
    checkOutput("rand_err", bus.err_o, 0);
    checkOutput("rand_cnt_end", bus.out_cnt_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
